// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; IF lookup, ID training, registered redirect.
// Lookup is combinational (0 cycles); the mispredict/redirect output is registered (1 cycle after update).
// No backpressure: one lookup and one update are accepted every cycle. Optional macro GSHARE_EN enables gshare counter indexing.
module branch_predictor #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_target,
   input  logic                  update_valid,
   input  logic [ADDR_WIDTH-1:0] update_pc,
   input  logic                  update_taken,
   input  logic [ADDR_WIDTH-1:0] update_target,
   input  logic                  update_pred_taken,
   input  logic [ADDR_WIDTH-1:0] update_pred_target,
   output logic                  mispredict_flag,
   output logic [ADDR_WIDTH-1:0] redirect_addr
);

   localparam int INDEX_BITS = $clog2(DEPTH);
   localparam int TAG_W      = ADDR_WIDTH - INDEX_BITS - 2;

   typedef logic [INDEX_BITS-1:0] idx_t;
   typedef logic [TAG_W-1:0]      tag_t;

   // BTB entry fields; counters are a separate array so gshare can index them differently
   logic                  valid_q  [DEPTH];
   tag_t                  tag_q    [DEPTH];
   logic [ADDR_WIDTH-1:0] target_q [DEPTH];
   logic [1:0]            ctr_q    [DEPTH];

   idx_t       l_idx, l_cidx, u_idx, u_cidx;
   tag_t       l_tag, u_tag;
   logic       l_hit, u_hit, u_mis;
   logic [1:0] ctr_cur, ctr_upd;

   // Instruction alignment bits of the fetch PC carry no information for the table
   logic unused_align;
   assign unused_align = ^lookup_pc[1:0];

   assign l_idx = lookup_pc[INDEX_BITS+1:2];
   assign l_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
   assign u_idx = update_pc[INDEX_BITS+1:2];
   assign u_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+2];

`ifdef GSHARE_EN
   logic [INDEX_BITS-1:0] ghr;

   assign l_cidx = l_idx ^ ghr;
   assign u_cidx = u_idx ^ ghr;

   // Global history: shift in each resolved direction; the update in the same cycle uses the old value
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr <= '0;
      end else if (update_valid) begin
         ghr <= {ghr[INDEX_BITS-2:0], update_taken};
      end
   end
`else
   assign l_cidx = l_idx;
   assign u_cidx = u_idx;
`endif

   // Lookup reads registered state only, so a same-cycle update is never bypassed
   always_comb begin
      l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
      pred_taken  = l_hit && ctr_q[l_cidx][1];
      pred_target = pred_taken ? target_q[l_idx] : '0;
   end

   // Resolution: hit detection, mispredict condition and saturating counter step
   always_comb begin
      u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      u_mis   = (update_taken != update_pred_taken) ||
                (update_taken && (update_target != update_pred_target));
      ctr_cur = ctr_q[u_cidx];
      ctr_upd = ctr_cur;
      if (update_taken) begin
         if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
      end else begin
         if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
      end
   end

   // Table training; reset wins over a concurrent update so the clearing edge writes nothing
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (update_valid) begin
         if (u_hit) begin
            ctr_q[u_cidx] <= ctr_upd;
            if (update_taken) target_q[u_idx] <= update_target;
         end else if (update_taken) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= update_target;
            ctr_q[u_cidx]   <= 2'b10;
         end
      end
   end

   // Registered redirect; the address only moves on a mispredict so it holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict_flag <= 1'b0;
         redirect_addr   <= '0;
      end else begin
         mispredict_flag <= update_valid && u_mis;
         if (update_valid && u_mis) begin
            redirect_addr <= update_taken ? update_target : update_pc + ADDR_WIDTH'(4);
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (DEPTH=16, default build).
// Directed scenarios plus a randomized run against an array-based reference model.
module tb_branch_predictor;

   localparam int AW = 32;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] lookup_pc = '0;
   logic          pred_taken;
   logic [AW-1:0] pred_target;
   logic          update_valid = 1'b0;
   logic [AW-1:0] update_pc = '0;
   logic          update_taken = 1'b0;
   logic [AW-1:0] update_target = '0;
   logic          update_pred_taken = 1'b0;
   logic [AW-1:0] update_pred_target = '0;
   logic          mispredict_flag;
   logic [AW-1:0] redirect_addr;

   int total = 0;
   int bad   = 0;

   branch_predictor #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
      .update_target(update_target), .update_pred_taken(update_pred_taken),
      .update_pred_target(update_pred_target),
      .mispredict_flag(mispredict_flag), .redirect_addr(redirect_addr)
   );

   always #5 clk = ~clk;

   // Reference model: table keyed by word index mod DEPTH, tag = pc / 64
   bit            m_valid [D];
   logic [AW-1:0] m_tag   [D];
   logic [AW-1:0] m_tgt   [D];
   int            m_ctr   [D];
   logic          exp_mf;
   logic [AW-1:0] exp_ra;

   function automatic int idx_of(logic [AW-1:0] pc);
      return int'((pc >> 2) % D);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      exp_mf = 1'b0;
      exp_ra = '0;
   endtask

   task automatic model_predict(input logic [AW-1:0] pc, output bit t, output logic [AW-1:0] tg);
      int  i;
      bit  hit;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == (pc >> 6));
      t   = hit && (m_ctr[i] >= 2);
      tg  = t ? m_tgt[i] : '0;
   endtask

   task automatic model_update(input logic [AW-1:0] pc, input bit taken, input logic [AW-1:0] tgt,
                               input bit pt, input logic [AW-1:0] ptg);
      int i;
      bit hit, mis;
      mis    = (taken != pt) || (taken && (tgt != ptg));
      exp_mf = mis;
      if (mis) exp_ra = taken ? tgt : pc + 32'd4;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == (pc >> 6));
      if (hit) begin
         if (taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (taken) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = pc >> 6;
         m_tgt[i]   = tgt;
         m_ctr[i]   = 2;
      end
   endtask

   // Drive one resolution for a single clock, then advance the model
   task automatic do_update(input logic [AW-1:0] pc, input bit taken, input logic [AW-1:0] tgt,
                            input bit pt, input logic [AW-1:0] ptg);
      update_valid       = 1'b1;
      update_pc          = pc;
      update_taken       = taken;
      update_target      = tgt;
      update_pred_taken  = pt;
      update_pred_target = ptg;
      @(posedge clk);
      #1;
      model_update(pc, taken, tgt, pt, ptg);
      update_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      update_valid = 1'b0;
      @(posedge clk);
      #1;
      exp_mf = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      lookup_pc = 32'h0040_0020;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); end
      total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL reset_pred_target got=%h exp=0", pred_target); end
      total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL reset_mf got=%b exp=0", mispredict_flag); end
      total++; if (redirect_addr !== 32'h0) begin bad++; $display("FAIL reset_ra got=%h exp=0", redirect_addr); end
   endtask

   task automatic test_train_and_untrain();
      do_update(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
      total++; if (mispredict_flag !== 1'b1) begin bad++; $display("FAIL alloc_mf got=%b exp=1", mispredict_flag); end
      total++; if (redirect_addr !== 32'h0040_0100) begin bad++; $display("FAIL alloc_ra got=%h exp=00400100", redirect_addr); end
      idle_cycle();
      total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b exp=0", mispredict_flag); end
      lookup_pc = 32'h0040_0020;
      #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_lookup_taken got=%b exp=1", pred_taken); end
      total++; if (pred_target !== 32'h0040_0100) begin bad++; $display("FAIL alloc_lookup_target got=%h exp=00400100", pred_target); end
      do_update(32'h0040_0020, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
      total++; if (mispredict_flag !== 1'b1) begin bad++; $display("FAIL nt_mf got=%b exp=1", mispredict_flag); end
      total++; if (redirect_addr !== 32'h0040_0024) begin bad++; $display("FAIL nt_ra got=%h exp=00400024", redirect_addr); end
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL nt_lookup_taken got=%b exp=0", pred_taken); end
      total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL nt_lookup_target got=%h exp=0", pred_target); end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 4; k++) begin
         do_update(32'h0040_0040, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400);
         total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL sat_mf_%0d got=%b exp=0", k, mispredict_flag); end
      end
      do_update(32'h0040_0040, 1'b0, 32'h0, 1'b1, 32'h0040_0400);
      total++; if (mispredict_flag !== 1'b1) begin bad++; $display("FAIL sat_nt_mf got=%b exp=1", mispredict_flag); end
      lookup_pc = 32'h0040_0040;
      #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_lookup_taken got=%b exp=1", pred_taken); end
      total++; if (pred_target !== 32'h0040_0400) begin bad++; $display("FAIL sat_lookup_target got=%h exp=00400400", pred_target); end
   endtask

   task automatic test_alias();
      do_update(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
      lookup_pc = 32'h0040_0020;
      #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_setup got=%b exp=1", pred_taken); end
      lookup_pc = 32'h0040_0060;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_other_tag got=%b exp=0", pred_taken); end
      do_update(32'h0040_0060, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
      lookup_pc = 32'h0040_0020;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted got=%b exp=0", pred_taken); end
      lookup_pc = 32'h0040_0060;
      #1;
      total++; if (pred_target !== 32'h0040_0200) begin bad++; $display("FAIL alias_new_target got=%h exp=00400200", pred_target); end
   endtask

   task automatic test_target_and_hold();
      // Right direction, wrong target: still a mispredict
      do_update(32'h0040_0060, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
      total++; if (mispredict_flag !== 1'b1) begin bad++; $display("FAIL tgt_mis_mf got=%b exp=1", mispredict_flag); end
      total++; if (redirect_addr !== 32'h0040_0300) begin bad++; $display("FAIL tgt_mis_ra got=%h exp=00400300", redirect_addr); end
      // Correct prediction leaves redirect_addr untouched
      do_update(32'h0040_0060, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
      total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL hold_mf got=%b exp=0", mispredict_flag); end
      total++; if (redirect_addr !== 32'h0040_0300) begin bad++; $display("FAIL hold_ra got=%h exp=00400300", redirect_addr); end
      // Fall-through address wraps at the top of the address space
      do_update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
      total++; if (redirect_addr !== 32'h0) begin bad++; $display("FAIL wrap_ra got=%h exp=0", redirect_addr); end
   endtask

   task automatic test_reset_mid();
      bit            et;
      logic [AW-1:0] etg;
      do_update(32'h0040_0100, 1'b1, 32'h0040_0800, 1'b0, 32'h0);
      rst                = 1'b1;
      update_valid       = 1'b1;
      update_pc          = 32'h0040_0144;
      update_taken       = 1'b1;
      update_target      = 32'h0040_0900;
      update_pred_taken  = 1'b0;
      update_pred_target = 32'h0;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      update_valid = 1'b0;
      model_reset();
      total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL rstmid_mf got=%b exp=0", mispredict_flag); end
      total++; if (redirect_addr !== 32'h0) begin bad++; $display("FAIL rstmid_ra got=%h exp=0", redirect_addr); end
      for (int k = 0; k < 64; k++) begin
         lookup_pc = 32'h0040_0000 + 32'(k * 4) + ((k % 2 == 1) ? 32'h100 : 32'h0);
         #0.1;
         model_predict(lookup_pc, et, etg);
         total++; if (pred_taken !== et) begin bad++; $display("FAIL rstmid_lookup pc=%h got=%b exp=%b", lookup_pc, pred_taken, et); end
      end
      idle_cycle();
      total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL rstmid_after_mf got=%b exp=0", mispredict_flag); end
   endtask

   task automatic test_random();
      bit            et, taken, pt;
      logic [AW-1:0] etg, pc, tgt, ptg;
      for (int n = 0; n < 400; n++) begin
         pc        = 32'h0040_0000 + ($urandom_range(0, 63) << 2);
         lookup_pc = pc;
         #1;
         model_predict(pc, et, etg);
         total++; if (pred_taken !== et) begin bad++; $display("FAIL rnd_taken n=%0d pc=%h got=%b exp=%b", n, pc, pred_taken, et); end
         total++; if (pred_target !== etg) begin bad++; $display("FAIL rnd_target n=%0d pc=%h got=%h exp=%h", n, pc, pred_target, etg); end
         taken = ($urandom % 4) != 0;
         tgt   = taken ? 32'h0050_0000 + ($urandom_range(0, 7) << 2) : 32'h0;
         pt    = et;
         ptg   = etg;
         if ($urandom % 5 == 0) pt = ~pt;
         if ($urandom % 5 == 0) ptg = tgt;
         do_update(pc, taken, tgt, pt, ptg);
         total++; if (mispredict_flag !== exp_mf) begin bad++; $display("FAIL rnd_mf n=%0d got=%b exp=%b", n, mispredict_flag, exp_mf); end
         total++; if (redirect_addr !== exp_ra) begin bad++; $display("FAIL rnd_ra n=%0d got=%h exp=%h", n, redirect_addr, exp_ra); end
         if ($urandom % 6 == 0) begin
            idle_cycle();
            total++; if (mispredict_flag !== 1'b0) begin bad++; $display("FAIL rnd_idle_mf n=%0d got=%b exp=0", n, mispredict_flag); end
            total++; if (redirect_addr !== exp_ra) begin bad++; $display("FAIL rnd_idle_ra n=%0d got=%h exp=%h", n, redirect_addr, exp_ra); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_train_and_untrain();
      test_saturation();
      test_alias();
      test_target_and_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised successor to the ID-stage branch resolution logic. Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters.
- Consulted in IF to predict the next PC.
- Trained from ID with the resolved outcome.
- Emits a registered mispredict/redirect to the PC generator one cycle after each resolution.

Parameters:
ADDR_WIDTH, 32, PC/target width in bits
DEPTH, 16, BTB entries; power of two, >= 4
INDEX_BITS, log2(DEPTH), derived; not overridden

Ports:
clk  in  1  clock
rst  in  1  reset
lookup_pc  in  ADDR_WIDTH  IF-stage PC
pred_taken  out  1  prediction: taken
pred_target  out  ADDR_WIDTH  predicted target; 0 when pred_taken=0
update_valid  in  1  ID resolved a branch/jump this cycle
update_pc  in  ADDR_WIDTH  PC of resolved branch
update_taken  in  1  actual direction
update_target  in  ADDR_WIDTH  actual target (valid when taken)
update_pred_taken  in  1  prediction that branch carried down the pipe
update_pred_target  in  ADDR_WIDTH  predicted target carried down the pipe
mispredict_flag  out  1  registered; 1-cycle pulse
redirect_addr  out  ADDR_WIDTH  registered correct fetch address

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
- Entry fields: valid, tag, target, ctr[1:0].
- Reset:
  - All valid=0; all ctr=2'b01.
  - mispredict_flag=0, redirect_addr=0.
  - Reset mid-operation discards any pending update; the clearing clock edge writes no table entry.
- Lookup (combinational from registered table, 0 latency):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = entry target if pred_taken, else 0.
- Update (on clk edge when update_valid=1):
  - Hit, taken: ctr saturating increment (max 2'b11); target <= update_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate (overwrite) with valid=1, new tag, target=update_target, ctr=2'b10.
  - Miss, not taken: no write.
- Mispredict (registered; visible cycle after update_valid):
  - mis = (update_taken != update_pred_taken) || (update_taken && update_target != update_pred_target).
  - mispredict_flag <= update_valid && mis.
  - redirect_addr <= update_taken ? update_target : update_pc + 4 (ADDR_WIDTH wrap-around); holds previous value when not mispredicting.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents. No bypass.
- Counter arithmetic never wraps: 11+1=11, 00-1=00.

Optional Feature:
GSHARE_EN
- Defined:
  - Adds an INDEX_BITS-wide global history register ghr, reset to 0.
  - Counter index = pc index XOR ghr, for both lookup and update. Update uses ghr before shift.
  - On each update_valid, ghr <= {ghr[INDEX_BITS-2:0], update_taken}.
  - Valid/tag/target remain indexed by pc index only; counter array is separate.
  - Allocation on miss also writes the XOR-indexed counter to 2'b10.
- Undefined: no ghr; counters co-indexed with the BTB entry.

Test Plan:
All scenarios use DEPTH=16, GSHARE_EN undefined.
1. Reset, then lookup_pc=0x00400020 -> pred_taken=0, pred_target=0, mispredict_flag=0, redirect_addr=0.
2. Update pc=0x00400020, taken=1, target=0x00400100, pred_taken=0 -> next cycle mispredict_flag=1 for one cycle, redirect_addr=0x00400100; subsequent lookup 0x00400020 -> pred_taken=1, pred_target=0x00400100.
3. From 2, update same pc with taken=0, pred_taken=1 -> mispredict_flag=1, redirect_addr=0x00400024; ctr=01, lookup pred_taken=0.
4. Saturation: 4 taken updates on 0x00400040 (correct pred/target supplied), then 1 not-taken -> lookup still pred_taken=1 (ctr 11->10); mispredict_flag=0 for all correctly predicted updates.
5. Aliasing: entry for 0x00400020 valid/taken; lookup 0x00400060 (same index 8, different tag) -> pred_taken=0; taken update for 0x00400060 evicts, then lookup 0x00400020 -> pred_taken=0.
6. Assert rst for one cycle while update_valid=1 with a mispredict -> mispredict_flag stays 0; all lookups afterwards pred_taken=0.
